imm_extend_stage: RTL and testbench

Parametrised, pipelined immediate-extension stage for the MIPS datapath, the successor to the fixed 10→32 sign extender. It takes an IN_W-bit immediate plus a mode select and a sideband tag, and produces an OUT_W-bit operand. Four extension modes are supported. Inputs and outputs use valid/ready handshakes, with a two-entry skid buffer so decode-to-execute flow keeps full throughput under backpressure.

---
 rtl/imm_ext_pkg.sv | 14 +
 rtl/imm_ext_core.sv | 32 +++
 rtl/imm_extend_stage.sv | 99 +++++++++
 tb/tb_imm_extend_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension datapath: mode encoding and
// the width of the mode field.
package imm_ext_pkg;

  localparam int IMM_MODE_W = 2;

  typedef enum logic [IMM_MODE_W-1:0] {
    IMM_SEXT      = 2'd0,
    IMM_ZEXT      = 2'd1,
    IMM_UPPER     = 2'd2,
    IMM_SEXT_SHL2 = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender, shared by the decode stage and the
// branch unit. IN_W must lie in 2..OUT_W-2.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       imm_i,
  input  logic [IMM_MODE_W-1:0] mode_i,
  output logic [OUT_W-1:0]      ext_o
);

  localparam int FILL_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_s;

  assign sext_s = {{FILL_W{imm_i[IN_W-1]}}, imm_i};

  // Mode select; the shifted form drops the top two sign bits (branch offset).
  always_comb begin
    ext_o = {OUT_W{1'b0}};
    case (imm_mode_e'(mode_i))
      IMM_SEXT:      ext_o = sext_s;
      IMM_ZEXT:      ext_o = {{FILL_W{1'b0}}, imm_i};
      IMM_UPPER:     ext_o = {imm_i, {FILL_W{1'b0}}};
      IMM_SEXT_SHL2: ext_o = {sext_s[OUT_W-3:0], 2'b00};
      default:       ext_o = sext_s;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Pipelined immediate-extension stage: extends on the input side and stores
// only result+tag in a main register backed by a one-entry skid register.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag
);

  logic [OUT_W-1:0] ext_s;
  logic             accept_s;
  logic             pop_s;

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm_i  (in_imm),
    .mode_i (in_mode),
    .ext_o  (ext_s)
  );

  // in_ready depends only on stored state, never on out_ready.
  assign in_ready  = ~skid_valid_q;
  assign accept_s  = in_valid & in_ready;
  assign pop_s     = main_valid_q & out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_tag   = main_tag_q;

  // Next-state for main/skid; a skid drain excludes an accept since in_ready is low.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    if (pop_s && skid_valid_q) begin
      main_valid_d = 1'b1;
      main_data_d  = skid_data_q;
      main_tag_d   = skid_tag_q;
      skid_valid_d = 1'b0;
    end else if (accept_s && (!main_valid_q || pop_s)) begin
      main_valid_d = 1'b1;
      main_data_d  = ext_s;
      main_tag_d   = in_tag;
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_s;
      skid_tag_d   = in_tag;
    end else if (pop_s) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // State registers; reset discards both entries asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= {OUT_W{1'b0}};
      main_tag_q   <= {TAG_W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {OUT_W{1'b0}};
      skid_tag_q   <= {TAG_W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed literal vectors, backpressure, random streaming and mid-cycle reset.
module tb_imm_extend_stage;

  localparam int IN_W  = 10;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm = '0;
  logic [1:0]        in_mode = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;

  logic              in_valid16 = 1'b0;
  logic              in_ready16;
  logic [15:0]       in_imm16 = '0;
  logic [1:0]        in_mode16 = '0;
  logic [TAG_W-1:0]  in_tag16 = '0;
  logic              out_valid16;
  logic              out_ready16 = 1'b1;
  logic [OUT_W-1:0]  out_data16;
  logic [TAG_W-1:0]  out_tag16;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [TAG_W-1:0] t;
  } beat_t;
  beat_t q[$];

  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_d = '0;
  logic [TAG_W-1:0] prev_t = '0;
  bit               stop = 1'b0;

  imm_extend_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_stage #(.IN_W(16), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_imm(in_imm16),
    .in_mode(in_mode16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .out_tag(out_tag16)
  );

  always #5 clk = ~clk;

  // Extension from arithmetic meaning: signed value, plain value, scaled values.
  function automatic logic [31:0] ref_ext(input int inw, input longint imm, input int mode);
    longint s;
    longint r;
    s = (imm >= (64'sd1 <<< (inw - 1))) ? imm - (64'sd1 <<< inw) : imm;
    case (mode)
      0:       r = s;
      1:       r = imm;
      2:       r = imm * (64'sd1 <<< (32 - inw));
      3:       r = s * 64'sd4;
      default: r = 64'sd0;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the FIFO model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_data", out_data, 32'd0);
      prev_stall <= 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      if (out_valid && q.size() > 0) begin
        check("out_data", out_data, q[0].d);
        check("out_tag", {27'd0, out_tag}, {27'd0, q[0].t});
      end
      if (prev_stall) begin
        check("hold_data", out_data, prev_d);
        check("hold_tag", {27'd0, out_tag}, {27'd0, prev_t});
      end
      prev_stall <= out_valid && !out_ready;
      prev_d     <= out_data;
      prev_t     <= out_tag;
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{ref_ext(IN_W, longint'(in_imm), int'(in_mode)), in_tag});
    end
  end

  task automatic push_beat(input logic [IN_W-1:0] imm, input logic [1:0] mode, input logic [TAG_W-1:0] tag);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL accept_timeout: got no accept, expected accept for tag %0d", tag);
    end
  endtask

  task automatic lit(input logic [IN_W-1:0] imm, input logic [1:0] mode, input logic [31:0] exp);
    check("model_lit", ref_ext(IN_W, longint'(imm), int'(mode)), exp);
    push_beat(imm, mode, 5'(mode));
    @(negedge clk);
    check("lit_valid", {31'd0, out_valid}, 32'd1);
    check("lit_data", out_data, exp);
  endtask

  task automatic drain();
    bit empty = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !empty; k++) begin
      @(negedge clk);
      if (q.size() == 0) empty = 1'b1;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Literal vectors with no backpressure.
    lit(10'h200, 2'd0, 32'hFFFF_FE00);
    lit(10'h200, 2'd1, 32'h0000_0200);
    lit(10'h200, 2'd2, 32'h8000_0000);
    lit(10'h200, 2'd3, 32'hFFFF_F800);
    lit(10'h1FF, 2'd0, 32'h0000_01FF);
    lit(10'h1FF, 2'd2, 32'h7FC0_0000);
    lit(10'h1FF, 2'd3, 32'h0000_07FC);
    lit(10'h3FF, 2'd3, 32'hFFFF_FFFC);
    drain();

    // Wider immediate build.
    in_valid16 = 1'b1;
    in_imm16   = 16'h8000;
    in_mode16  = 2'd2;
    @(posedge clk);
    #1;
    in_mode16 = 2'd0;
    @(negedge clk);
    check("w16_upper", out_data16, 32'h8000_0000);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    @(negedge clk);
    check("w16_sext", out_data16, 32'hFFFF_8000);
    @(posedge clk);
    #1;

    // Backpressure: two absorbed, third held, then ordered drain.
    out_ready = 1'b0;
    push_beat(10'h011, 2'd1, 5'd1);
    push_beat(10'h022, 2'd1, 5'd2);
    in_valid = 1'b1;
    in_imm   = 10'h033;
    in_mode  = 2'd1;
    in_tag   = 5'd3;
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_tag1", {27'd0, out_tag}, 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out1", {27'd0, out_tag}, 32'd1);
    @(negedge clk);
    check("bp_out2", {27'd0, out_tag}, 32'd2);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_out3", {27'd0, out_tag}, 32'd3);
    check("bp_out3_data", out_data, 32'h0000_0033);
    drain();

    // Random stream with random backpressure.
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          push_beat(10'($urandom), 2'($urandom), 5'($urandom));
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Mid-cycle reset with both entries full.
    out_ready = 1'b0;
    push_beat(10'h155, 2'd0, 5'd9);
    push_beat(10'h0AA, 2'd2, 5'd10);
    @(negedge clk);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    push_beat(10'h005, 2'd1, 5'd4);
    @(negedge clk);
    check("post_rst_tag", {27'd0, out_tag}, 32'd4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
